au_out_i2s_tx: RTL and testbench

I2S transmit serializer that sits directly downstream of the audio output PIO in the Nios audio system. It takes the 16-bit two's-complement sample held on the PIO's `out_port` and serializes it to the audio codec DAC. The block runs as I2S master: it generates BCLK and DACLRCK, and drives DACDAT. Each frame sends the same sample on the left and right channels.

---
 rtl/audio_i2s_pkg.sv | 29 ++
 rtl/i2s_bclk_gen.sv | 32 +++
 rtl/au_out_i2s_tx.sv | 74 +++++++
 tb/tb_au_out_i2s_tx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/audio_i2s_pkg.sv
// Shared I2S framing constants and slot classification for the audio output path.
package audio_i2s_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int L_MSB_SLOT = 1;
  localparam int R_MSB_SLOT = 33;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_LEFT,
    SLOT_RIGHT
  } slot_kind_e;

  // Which channel (if any) owns the data bit driven in a given BCLK slot.
  function automatic slot_kind_e slot_kind(input logic [BIT_CNT_W-1:0] slot);
    int s;
    s = int'(slot);
    if (s >= L_MSB_SLOT && s < L_MSB_SLOT + SAMPLE_W)
      return SLOT_LEFT;
    else if (s >= R_MSB_SLOT && s < R_MSB_SLOT + SAMPLE_W)
      return SLOT_RIGHT;
    else
      return SLOT_IDLE;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles bclk every BCLK_DIV clk cycles and flags the cycle
// whose clock edge will drive bclk from 1 to 0.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic bclk,
  output logic fall_evt
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tc;

  assign tc       = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign fall_evt = tc & bclk;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/au_out_i2s_tx.sv
// I2S master transmitter: serializes the PIO sample onto both channels of
// each 64-BCLK frame, MSB one BCLK after the word-clock edge.
module au_out_i2s_tx
  import audio_i2s_pkg::*;
#(
  parameter int BCLK_DIV = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       mute,
  output logic                       aud_bclk,
  output logic                       aud_daclrck,
  output logic                       aud_dacdat,
  output logic                       frame_tick
);

  logic                       fall_evt;
  logic [BIT_CNT_W-1:0]       bit_cnt;
  logic [BIT_CNT_W-1:0]       bit_nxt;
  logic signed [SAMPLE_W-1:0] shift_l;
  logic signed [SAMPLE_W-1:0] shift_r;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .bclk     (aud_bclk),
    .fall_evt (fall_evt)
  );

  assign bit_nxt = bit_cnt + 1'b1;

  // All serial outputs update on the same clk edge that drops BCLK, so they
  // are settled long before the codec samples on the next rise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt     <= '1;
      shift_l     <= '0;
      shift_r     <= '0;
      aud_daclrck <= 1'b0;
      aud_dacdat  <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (fall_evt) begin
        bit_cnt    <= bit_nxt;
        aud_dacdat <= 1'b0;
        unique case (slot_kind(bit_nxt))
          SLOT_LEFT: begin
            aud_dacdat <= shift_l[SAMPLE_W-1];
            shift_l    <= shift_l << 1;
          end
          SLOT_RIGHT: begin
            aud_dacdat <= shift_r[SAMPLE_W-1];
            shift_r    <= shift_r << 1;
          end
          default: ;
        endcase
        // Frame start: the only point where sample_in and mute are observed.
        if (bit_nxt == '0) begin
          frame_tick  <= 1'b1;
          aud_daclrck <= 1'b0;
          shift_l     <= mute ? '0 : sample_in;
          shift_r     <= mute ? '0 : sample_in;
        end
        if (bit_nxt == BIT_CNT_W'(SLOT_BITS))
          aud_daclrck <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_au_out_i2s_tx.sv
// Bench for au_out_i2s_tx: waveform model derived from clk-edge arithmetic
// since reset release, with directed scenarios followed by random traffic.
module tb_au_out_i2s_tx;

  localparam int DIV   = 2;
  localparam int P     = 2 * DIV;
  localparam int FRAME = 64 * P;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        frame_tick;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n = 0;
  logic [15:0] cur = 16'h0000;

  au_out_i2s_tx #(.BCLK_DIV(DIV)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_in   (sample_in),
    .mute        (mute),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .aud_dacdat  (aud_dacdat),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, n, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Slot just entered at edge n (valid only when at least one fall has happened).
  function automatic int cur_slot();
    return ((n / P) - 1) % 64;
  endfunction

  // One clk: advance the model on the rising edge, compare on the falling edge.
  task automatic step();
    int   k;
    int   s;
    logic e_bclk, e_lr, e_dat, e_tick;
    @(posedge clk);
    if (!reset_n) begin
      n = 0;
    end else begin
      n++;
      if (n % P == 0 && cur_slot() == 0)
        cur = mute ? 16'h0000 : sample_in;
    end
    @(negedge clk);
    k      = n / P;
    e_bclk = ((n / DIV) % 2) == 1;
    e_lr   = 1'b0;
    e_dat  = 1'b0;
    e_tick = 1'b0;
    if (k >= 1) begin
      s      = cur_slot();
      e_lr   = (s >= 32);
      e_tick = (n % P == 0) && (s == 0);
      if (s >= 1 && s <= 16)  e_dat = cur[16 - s];
      if (s >= 33 && s <= 48) e_dat = cur[48 - s];
    end
    check_bit("bclk", aud_bclk, e_bclk);
    check_bit("lrck", aud_daclrck, e_lr);
    check_bit("dacdat", aud_dacdat, e_dat);
    check_bit("frame_tick", frame_tick, e_tick);
  endtask

  task automatic run_to_slot(input int target);
    int guard = 0;
    do begin
      step();
      guard++;
    end while (!(n > 0 && n % P == 0 && cur_slot() == target) && guard < 2 * FRAME);
    check_int("slot_wait_in_budget", int'(guard < 2 * FRAME), 1);
  endtask

  task automatic clocks_to_tick(input string tag, input int exp);
    int t = 0;
    do begin
      step();
      t++;
    end while (frame_tick !== 1'b1 && t < 2 * FRAME);
    check_int(tag, t, exp);
  endtask

  initial begin
    // Reset: outputs must sit at their reset values.
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    sample_in = 16'h0000;
    clocks_to_tick("first_tick_latency", P);
    run_to_slot(0);

    // Held pattern on both channels.
    sample_in = 16'hA5C3;
    run_to_slot(0);
    run_to_slot(0);

    // Mid-frame change must not tear the current frame.
    sample_in = 16'h1234;
    run_to_slot(0);
    run_to_slot(10);
    sample_in = 16'h8001;
    run_to_slot(0);
    run_to_slot(0);

    // Mute sampled only at frame start.
    sample_in = 16'h7FFF;
    mute = 1'b1;
    run_to_slot(0);
    run_to_slot(5);
    mute = 1'b0;
    run_to_slot(0);
    run_to_slot(0);

    // One-clk reset inside the right-channel half.
    run_to_slot(40);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    clocks_to_tick("tick_after_midframe_reset", P);

    // Free run: tick period is one frame.
    for (int f = 0; f < 4; f++)
      clocks_to_tick("tick_period", FRAME);

    // Random samples and mute toggles at arbitrary times.
    for (int c = 0; c < 6 * FRAME; c++) begin
      step();
      if ($urandom_range(15) == 0) sample_in = 16'($urandom);
      if ($urandom_range(63) == 0) mute = ~mute;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
